// File: rtl/instruction_sequencer_if.sv
// Bus between an instruction_sequencer and the agent that loads its program
// and controls playback. The master drives the loads and controls; the sequencer is the slave.
interface instruction_sequencer_if #(
  parameter int PC_W     = 8,
  parameter int REPEAT_W = 16
);
  logic                load_write_i;
  logic [PC_W-1:0]     load_address_i;
  logic [16:0]         load_data_i;
  logic                start_i;
  logic [PC_W-1:0]     last_i;
  logic [REPEAT_W-1:0] repeat_i;
  logic                hold_i;
  logic [16:0]         instruction_o;
  logic                valid_o;
  logic                busy_o;
  logic                done_o;
  logic [PC_W-1:0]     pc_o;
  logic [REPEAT_W-1:0] pass_o;

  modport master (
    output load_write_i, load_address_i, load_data_i,
    output start_i, last_i, repeat_i, hold_i,
    input  instruction_o, valid_o, busy_o, done_o, pc_o, pass_o
  );

  modport slave (
    input  load_write_i, load_address_i, load_data_i,
    input  start_i, last_i, repeat_i, hold_i,
    output instruction_o, valid_o, busy_o, done_o, pc_o, pass_o
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Plays a stored microprogram, from PC 0 to a latched last PC, for repeat+1 passes.
// One 17-bit word is issued per unstalled cycle. A NOP is issued while the core is held.
module instruction_sequencer #(
  parameter int PROG_DEPTH = 256,
  parameter int PC_W       = 8,
  parameter int REPEAT_W   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  instruction_sequencer_if.slave  bus
);
  localparam logic [16:0]     NOP      = 17'h0;
  localparam logic [PC_W-1:0] LAST_MAX = PC_W'(PROG_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [16:0]         r_mem [PROG_DEPTH];
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     r_last;
  logic [REPEAT_W-1:0] r_pass;
  logic [REPEAT_W-1:0] r_repeat;
  logic [16:0]         r_instruction;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  logic                w_load_en;
  logic [PC_W-1:0]     w_last_clamped;
  logic                w_pc_at_last;
  logic                w_final_pass;

  // A load is accepted only in IDLE, so a write never collides with a playback read.
  assign w_load_en      = bus.load_write_i && (r_state == IDLE);
  assign w_last_clamped = ({1'b0, bus.last_i} >= (PC_W+1)'(PROG_DEPTH)) ? LAST_MAX : bus.last_i;
  assign w_pc_at_last   = (r_pc == r_last);
  assign w_final_pass   = (r_pass == r_repeat);

  // NOTE: the program RAM has no reset. A reset must not erase the loaded
  // program, and a RAM without a reset can map to block memory.
  always_ff @(posedge clk_i) begin
    if (w_load_en) begin
      r_mem[bus.load_address_i] <= bus.load_data_i;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments. Every register then
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_last        <= '0;
      r_pass        <= '0;
      r_repeat      <= '0;
      r_instruction <= NOP;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_instruction <= NOP;
          r_valid       <= 1'b0;
          r_done        <= 1'b0;
          if (bus.start_i) begin
            r_last   <= w_last_clamped;
            r_repeat <= bus.repeat_i;
            r_pc     <= '0;
            r_pass   <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end

        RUN: begin
          r_done <= 1'b0;
          if (bus.hold_i) begin
            r_instruction <= NOP;
            r_valid       <= 1'b0;
          end else begin
            r_instruction <= r_mem[r_pc];
            r_valid       <= 1'b1;
            if (w_pc_at_last) begin
              // Start the next pass with no bubble. Stop after the final pass.
              r_pc <= '0;
              if (w_final_pass) begin
                r_state <= DONE;
              end else begin
                r_pass <= r_pass + 1'b1;
              end
            end else begin
              r_pc <= r_pc + 1'b1;
            end
          end
        end

        DONE: begin
          r_instruction <= NOP;
          r_valid       <= 1'b0;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end

        default: begin
          r_instruction <= NOP;
          r_valid       <= 1'b0;
          r_done        <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.instruction_o = r_instruction;
  assign bus.valid_o       = r_valid;
  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.pc_o          = r_pc;
  assign bus.pass_o        = r_pass;
endmodule
